// File: rtl/dice_pkg.sv
// Shared types, segment table and BCD helpers for the multi-button dice roller.
package dice_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROLL  = 2'd1,
    SHOW  = 2'd2,
    BLANK = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam int MAX_DIGITS = 4;
  localparam int MAX_BCD_W  = 4 * MAX_DIGITS;

  // Segment codes {g,f,e,d,c,b,a}, active-high; index = decimal digit
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
    7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] seg_decode(input bcd_t d);
    logic [6:0] code;
    code = 7'h00;
    if (d <= 4'd9) code = SEG_TABLE[d];
    return code;
  endfunction

  // Decrement a packed BCD value by one, borrowing across digits
  function automatic logic [MAX_BCD_W-1:0] bcd_dec(input logic [MAX_BCD_W-1:0] v);
    logic [MAX_BCD_W-1:0] res;
    logic                 borrow;
    res    = v;
    borrow = 1'b1;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (borrow) begin
        if (res[4*i +: 4] == 4'd0) begin
          res[4*i +: 4] = 4'd9;
        end else begin
          res[4*i +: 4] = res[4*i +: 4] - 4'd1;
          borrow        = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dice_debounce.sv
// One button input: 2-FF synchroniser, polarity normalisation and a
// tick-based stability filter that accepts a change after DEB_TICKS ticks.
module dice_debounce
#(
  parameter int DEB_TICKS = 2
)
(
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn_raw,
  input  logic btn_pol,
  output logic btn_deb
);

  localparam int CW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          deb_reg;
  logic          pressed;

  assign pressed = sync_reg[1] ^ ~btn_pol;
  assign btn_deb = deb_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg <= 2'b00;
      cnt_reg  <= '0;
      deb_reg  <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], btn_raw};
      if (tick) begin
        // Any tick that sees agreement restarts the run of differing ticks
        if (pressed != deb_reg) begin
          if (cnt_reg == CW'(DEB_TICKS - 1)) begin
            deb_reg <= pressed;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end else begin
          cnt_reg <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/dice_roller_multi.sv
// N-button dice roller: debounced die selection, BCD roll counter and a
// scanned 7-segment display. Define DICE_TIMEOUT_EN to blank after a timeout.
module dice_roller_multi
  import dice_pkg::*;
#(
  parameter int N_BTN    = 7,
  parameter int N_DIGITS = 3,
  parameter logic [N_BTN*4*N_DIGITS-1:0] SIDES_TABLE = {
    12'h100, 12'h020, 12'h012, 12'h010, 12'h008, 12'h006, 12'h004
  },
  parameter int TICK_DIV      = 1024,
  parameter int DEB_TICKS     = 2,
  parameter int SCAN_DIV      = 16,
  parameter int TIMEOUT_TICKS = 255
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_BTN-1:0]      btn,
  input  logic                  btn_pol,
  input  logic                  seg_pol,
  input  logic                  com_pol,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   com,
  output logic [4*N_DIGITS-1:0] result_bcd,
  output logic                  result_valid,
  output logic                  rolling
);

  localparam int RW = 4 * N_DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  state_t            state_reg, state_next;
  logic [TW-1:0]     tick_cnt_reg;
  logic              tick;
  logic [N_BTN-1:0]  btn_deb;
  logic              any_btn;
  logic [RW-1:0]     sel_sides;
  logic [RW-1:0]     sides_reg;
  logic [RW-1:0]     result_reg;
  logic [RW-1:0]     result_dec;
  logic              disp_en;
  logic [SW-1:0]     scan_div_reg;
  logic [DW-1:0]     scan_idx_reg;
  logic [N_DIGITS-1:0] digit_on;
  logic [N_DIGITS-1:0] com_raw;
  bcd_t              cur_digit;
  logic [6:0]        seg_raw;

  // Free-running timebase for debounce and timeout
  assign tick = (tick_cnt_reg == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_reg <= '0;
    else        tick_cnt_reg <= tick ? '0 : tick_cnt_reg + 1'b1;
  end

  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_deb
    dice_debounce #(
      .DEB_TICKS (DEB_TICKS)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .btn_raw (btn[gi]),
      .btn_pol (btn_pol),
      .btn_deb (btn_deb[gi])
    );
  end

  assign any_btn = |btn_deb;

  // Lowest-index pressed button wins
  always_comb begin
    sel_sides = SIDES_TABLE[RW-1:0];
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (btn_deb[i]) sel_sides = SIDES_TABLE[i*RW +: RW];
    end
  end

`ifdef DICE_TIMEOUT_EN
  localparam int OW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  logic [OW-1:0] timeout_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_reg <= '0;
    end else if (state_reg == ROLL && !any_btn) begin
      timeout_reg <= OW'(TIMEOUT_TICKS);
    end else if (state_reg == SHOW && tick && timeout_reg != '0) begin
      timeout_reg <= timeout_reg - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ROLL: if (!any_btn) state_next = SHOW;
      SHOW: begin
        if (any_btn) state_next = ROLL;
`ifdef DICE_TIMEOUT_EN
        else if (timeout_reg == '0) state_next = BLANK;
`endif
      end
      default: if (any_btn) state_next = ROLL;
    endcase
  end

  always_comb begin
    rolling      = (state_reg == ROLL);
    result_valid = (state_reg == SHOW) || (state_reg == BLANK);
    disp_en      = (state_reg == SHOW);
  end

  assign result_dec = RW'(bcd_dec(MAX_BCD_W'(result_reg)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sides_reg  <= SIDES_TABLE[RW-1:0];
      result_reg <= RW'(1);
    end else if (state_reg != ROLL && any_btn) begin
      sides_reg  <= sel_sides;
      result_reg <= sel_sides;
    end else if (state_reg == ROLL && any_btn) begin
      result_reg <= (result_reg == RW'(1)) ? sides_reg : result_dec;
    end
  end

  assign result_bcd = result_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_div_reg <= '0;
      scan_idx_reg <= '0;
    end else if (scan_div_reg == SW'(SCAN_DIV - 1)) begin
      scan_div_reg <= '0;
      scan_idx_reg <= (scan_idx_reg == DW'(N_DIGITS - 1)) ? '0 : scan_idx_reg + 1'b1;
    end else begin
      scan_div_reg <= scan_div_reg + 1'b1;
    end
  end

  // A digit is lit only if it or a more significant digit is nonzero
  assign digit_on[0] = 1'b1;
  for (genvar gi = 1; gi < N_DIGITS; gi++) begin : g_lz
    assign digit_on[gi] = |result_reg[RW-1:4*gi];
  end

  always_comb begin
    cur_digit = '0;
    com_raw   = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scan_idx_reg == DW'(i)) begin
        cur_digit  = result_reg[4*i +: 4];
        com_raw[i] = disp_en & digit_on[i];
      end
    end
  end

  assign seg_raw = (|com_raw) ? seg_decode(cur_digit) : 7'h00;
  assign seg     = seg_raw ^ {7{~seg_pol}};
  assign com     = com_raw ^ {N_DIGITS{~com_pol}};

endmodule

// File: tb/tb_dice_roller_multi.sv
// Directed bench for dice_roller_multi with an integer-level roll/display model.
module tb_dice_roller_multi;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  btn = 7'h00;
  logic        btn_pol = 1'b1;
  logic        seg_pol = 1'b1;
  logic        com_pol = 1'b1;
  logic [6:0]  seg;
  logic [2:0]  com;
  logic [11:0] result_bcd;
  logic        result_valid;
  logic        rolling;

  always #5 clk = ~clk;

  dice_roller_multi #(
    .N_BTN         (7),
    .N_DIGITS      (3),
    .TICK_DIV      (8),
    .DEB_TICKS     (2),
    .SCAN_DIV      (4),
    .TIMEOUT_TICKS (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .btn_pol      (btn_pol),
    .seg_pol      (seg_pol),
    .com_pol      (com_pol),
    .seg          (seg),
    .com          (com),
    .result_bcd   (result_bcd),
    .result_valid (result_valid),
    .rolling      (rolling)
  );

  localparam logic [6:0] SEG_EXP [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  int checks = 0;
  int errors = 0;
  int press_sides = 1;
  int m_result = 1;
  int m_wraps = 0;
  int dut_max = 0;
  bit m_roll = 1'b0;
  bit m_valid = 1'b0;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd2int(input logic [11:0] b);
    return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic int ndig(input int v);
    return (v >= 100) ? 3 : (v >= 10) ? 2 : 1;
  endfunction

  function automatic logic [2:0] exp_mask(input int v);
    return (v >= 100) ? 3'b111 : (v >= 10) ? 3'b011 : 3'b001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: rolling value counts down from the chosen die size and wraps at 1
  always @(negedge clk) begin : compare
    logic [2:0] ac;
    logic [6:0] as;
    int k, d;
    ac = com ^ {3{~com_pol}};
    as = seg ^ {7{~seg_pol}};
    if (!rst_n) begin
      check("rst_result", result_bcd, 12'h001);
      check("rst_rolling", rolling, 1'b0);
      check("rst_valid", result_valid, 1'b0);
      check("rst_com", ac, 3'b000);
      check("rst_seg", as, 7'h00);
      m_result = 1;
      m_roll   = 1'b0;
      m_valid  = 1'b0;
    end else begin
      if (rolling) begin
        if (!m_roll) m_result = press_sides;
        else if (m_result == 1) begin
          m_result = press_sides;
          m_wraps++;
        end else m_result--;
        m_roll  = 1'b1;
        m_valid = 1'b0;
        if (bcd2int(result_bcd) > dut_max) dut_max = bcd2int(result_bcd);
      end else if (m_roll) begin
        m_roll  = 1'b0;
        m_valid = 1'b1;
      end
      check("result", result_bcd, to_bcd(m_result));
      check("valid", result_valid, m_valid);
      if (!m_valid) check("com_off", ac, 3'b000);
      if (ac == 3'b000) begin
        check("seg_off", as, 7'h00);
      end else begin
        check("com_onehot", $onehot(ac), 1'b1);
        k = 0;
        for (int i = 0; i < 3; i++) if (ac[i]) k = i;
        d = m_result;
        for (int i = 0; i < k; i++) d = d / 10;
        d = d % 10;
        check("digit_shown", k < ndig(m_result), 1'b1);
        check("seg", as, SEG_EXP[d]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] mask);
    #1;
    btn = btn_pol ? mask : ~mask;
  endtask

  task automatic wait_roll(input logic lvl, input string name);
    for (int n = 0; n < 40 && rolling !== lvl; n++) @(negedge clk);
    check(name, rolling, lvl);
  endtask

  task automatic window(output logic [2:0] seen);
    seen = 3'b000;
    repeat (12) begin
      @(negedge clk);
      seen |= com ^ {3{~com_pol}};
    end
  endtask

  logic [2:0] seen;
  int fin;

  initial begin
    step(3);
    #1 rst_n = 1'b1;

    // Idle after reset
    step(5);
    check("t1_result", result_bcd, 12'h001);
    check("t1_rolling", rolling, 1'b0);
    check("t1_valid", result_valid, 1'b0);
    check("t1_com", com, 3'b000);
    check("t1_seg", seg, 7'h00);

    // d4: sequence 4,3,2 then freeze
    dut_max = 0;
    press_sides = 4;
    drive(7'h01);
    wait_roll(1'b1, "t2_start");
    check("t2_r0", result_bcd, 12'h004);
    step(1);
    check("t2_r1", result_bcd, 12'h003);
    step(1);
    check("t2_r2", result_bcd, 12'h002);
    drive(7'h00);
    wait_roll(1'b0, "t2_stop");
    window(seen);
    check("t2_com", seen, 3'b001);
    check("t2_max", dut_max, 4);

    // d100 held long enough to wrap exactly once
    dut_max = 0;
    m_wraps = 0;
    press_sides = 100;
    drive(7'h40);
    wait_roll(1'b1, "t3_start");
    check("t3_r0", result_bcd, 12'h100);
    step(100);
    check("t3_held", rolling, 1'b1);
    drive(7'h00);
    wait_roll(1'b0, "t3_stop");
    fin = m_result;
    check("t3_wraps", m_wraps, 1);
    check("t3_max", dut_max, 100);
    window(seen);
    check("t3_scan", seen, exp_mask(fin));

    // btn5+btn1 -> d6, later btn0 ignored
    dut_max = 0;
    press_sides = 6;
    drive(7'b0100010);
    wait_roll(1'b1, "t4_start");
    check("t4_r0", result_bcd, 12'h006);
    step(3);
    drive(7'b0100011);
    step(40);
    check("t4_held", rolling, 1'b1);
    drive(7'h00);
    wait_roll(1'b0, "t4_stop");
    fin = m_result;
    window(seen);
    check("t4_com", seen, 3'b001);
    check("t4_max", dut_max, 6);

`ifdef DICE_TIMEOUT_EN
    step(50);
    window(seen);
    check("t5_blank_com", seen, 3'b000);
    check("t5_valid", result_valid, 1'b1);
    check("t5_held", result_bcd, to_bcd(fin));
`else
    step(1000);
    window(seen);
    check("t5_show_com", seen, 3'b001);
    check("t5_valid", result_valid, 1'b1);
    check("t5_held", result_bcd, to_bcd(fin));
`endif

    // Async reset mid-roll, then inverted polarities
    press_sides = 100;
    drive(7'h40);
    wait_roll(1'b1, "t6_start");
    step(5);
    #1 rst_n = 1'b0;
    #1;
    check("t6_result", result_bcd, 12'h001);
    check("t6_rolling", rolling, 1'b0);
    check("t6_valid", result_valid, 1'b0);
    check("t6_com", com, 3'b000);
    btn_pol = 1'b0;
    seg_pol = 1'b0;
    com_pol = 1'b0;
    btn     = 7'h7F;
    #1;
    check("t6_com_inv", com, 3'b111);
    check("t6_seg_inv", seg, 7'h7F);
    step(3);
    #1 rst_n = 1'b1;
    step(20);
    check("t6_idle", rolling, 1'b0);
    dut_max = 0;
    press_sides = 8;
    drive(7'h04);
    wait_roll(1'b1, "t6_inv_start");
    check("t6_r0", result_bcd, 12'h008);
    step(5);
    drive(7'h00);
    wait_roll(1'b0, "t6_inv_stop");
    window(seen);
    check("t6_scan", seen, 3'b001);
    check("t6_max", dut_max, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
